// File: rtl/cnt_dec_pkg.sv
// Shared types and constants for the step-counter observer (cnt_step_decoder).
package cnt_dec_pkg;

  // Decoder lock FSM.
  typedef enum logic [1:0] {
    StUnsync = 2'd0,
    StAcq    = 2'd1,
    StLocked = 2'd2
  } dec_state_e;

  // Step classes as modulo deltas between consecutive samples.
  localparam int unsigned STEP_HOLD = 0;
  localparam int unsigned STEP_INC2 = 2;

  // good_cnt is sized as $clog2(LOCK_N+1) for the largest legal LOCK_N,
  // so every LOCK_N in 1..15 fits without re-deriving the width.
  localparam int unsigned LOCK_N_MAX = 15;
  localparam int unsigned GOOD_CNT_W = $clog2(LOCK_N_MAX + 1);

endpackage

// File: rtl/cnt_step_classify.sv
// Combinational step classifier: modulo delta between the new and previous sample.
module cnt_step_classify
  import cnt_dec_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [CNT_W-1:0] prev_i,
  output logic             legal_o,
  output logic             is_inc2_o
);

  logic [CNT_W-1:0] delta;

  // Wrap-around falls out of the natural CNT_W-bit subtract (14->0 is +2).
  always_comb begin
    delta     = cnt_i - prev_i;
    is_inc2_o = (delta == CNT_W'(STEP_INC2));
    legal_o   = is_inc2_o | (delta == CNT_W'(STEP_HOLD));
  end

endmodule

// File: rtl/cnt_step_decoder.sv
// Observer for the +2/hold step counter: recovers per-cycle step, tracks lock
// and counts illegal steps seen while locked.
// Optional: CNT_STEP_DECODER_ERR_CNT_EN builds the saturating error counter;
// without it err_cnt_o is tied to zero.
module cnt_step_decoder
  import cnt_dec_pkg::*;
#(
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned LOCK_N = 4,
  parameter int unsigned ERR_W  = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             step_valid_o,
  output logic             inc2_o,
  output logic             err_o,
  output logic             locked_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  dec_state_e              state_d, state_q;
  logic [CNT_W-1:0]        prev_d, prev_q;
  logic [GOOD_CNT_W-1:0]   good_cnt_d, good_cnt_q;
  logic                    step_valid_d, step_valid_q;
  logic                    inc2_d, inc2_q;
  logic                    err_d, err_q;
  logic                    locked_d, locked_q;
  logic                    legal, is_inc2;

  cnt_step_classify #(
    .CNT_W (CNT_W)
  ) u_classify (
    .cnt_i     (cnt_i),
    .prev_i    (prev_q),
    .legal_o   (legal),
    .is_inc2_o (is_inc2)
  );

  // Next-state for FSM, prev sample, good-step count and step/err pulses.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    good_cnt_d   = good_cnt_q;
    step_valid_d = 1'b0;
    inc2_d       = 1'b0;
    err_d        = 1'b0;
    if (clear_i) begin
      // Sample is dropped; UNSYNC makes the stale prev irrelevant.
      state_d    = StUnsync;
      good_cnt_d = '0;
    end else if (valid_i) begin
      prev_d = cnt_i;
      unique case (state_q)
        StUnsync: begin
          state_d    = StAcq;
          good_cnt_d = '0;
        end
        StAcq: begin
          if (legal) begin
            step_valid_d = 1'b1;
            inc2_d       = is_inc2;
            good_cnt_d   = good_cnt_q + 1'b1;
            if (good_cnt_d == GOOD_CNT_W'(LOCK_N)) state_d = StLocked;
          end else begin
            good_cnt_d = '0;
          end
        end
        StLocked: begin
          if (legal) begin
            step_valid_d = 1'b1;
            inc2_d       = is_inc2;
          end else begin
            err_d      = 1'b1;
            state_d    = StAcq;
            good_cnt_d = '0;
          end
        end
        default: state_d = StUnsync;
      endcase
    end
    locked_d = (state_d == StLocked);
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StUnsync;
      prev_q       <= '0;
      good_cnt_q   <= '0;
      step_valid_q <= 1'b0;
      inc2_q       <= 1'b0;
      err_q        <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      good_cnt_q   <= good_cnt_d;
      step_valid_q <= step_valid_d;
      inc2_q       <= inc2_d;
      err_q        <= err_d;
      locked_q     <= locked_d;
    end
  end

  assign step_valid_o = step_valid_q;
  assign inc2_o       = inc2_q;
  assign err_o        = err_q;
  assign locked_o     = locked_q;

`ifdef CNT_STEP_DECODER_ERR_CNT_EN
  logic [ERR_W-1:0] err_cnt_d, err_cnt_q;

  // Saturating count, updated in step with the err_o pulse.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clear_i) begin
      err_cnt_d = '0;
    end else if (err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // Error counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cnt_step_decoder.sv
// Scoreboard bench for cnt_step_decoder: a reference model pushes the expected
// output word when a sample is driven; it is popped and compared one cycle later.
module tb_cnt_step_decoder;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned LOCK_N = 4;
  localparam int unsigned ERR_W  = 8;

  logic             clock   = 1'b0;
  logic             reset_n = 1'b0;
  logic             clear_i = 1'b0;
  logic             valid_i = 1'b0;
  logic [CNT_W-1:0] cnt_i   = '0;
  logic             step_valid_o, inc2_o, err_o, locked_o;
  logic [ERR_W-1:0] err_cnt_o;

  always #5 clock = ~clock;

  cnt_step_decoder #(
    .CNT_W  (CNT_W),
    .LOCK_N (LOCK_N),
    .ERR_W  (ERR_W)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear_i      (clear_i),
    .valid_i      (valid_i),
    .cnt_i        (cnt_i),
    .step_valid_o (step_valid_o),
    .inc2_o       (inc2_o),
    .err_o        (err_o),
    .locked_o     (locked_o),
    .err_cnt_o    (err_cnt_o)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  string       phase    = "reset";
  logic [11:0] exp_q[$];

  // Reference model: state 0=UNSYNC 1=ACQ 2=LOCKED.
  int         m_state   = 0;
  int         m_good    = 0;
  int         m_err_cnt = 0;
  logic [3:0] m_prev    = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [11:0] obs();
    return {step_valid_o, inc2_o, err_o, locked_o, err_cnt_o};
  endfunction

  function automatic logic [7:0] exp_err_cnt();
`ifdef CNT_STEP_DECODER_ERR_CNT_EN
    return 8'(m_err_cnt);
`else
    return 8'd0;
`endif
  endfunction

  task automatic model_reset();
    m_state   = 0;
    m_good    = 0;
    m_err_cnt = 0;
    exp_q.delete();
  endtask

  // One cycle: compare the previous cycle's expectation, drive, push new expectation.
  task automatic cycle(input logic v, input logic [3:0] c, input logic clr);
    logic       sv, inc, er;
    logic [3:0] d;
    @(negedge clock);
    if (exp_q.size() > 0) check(phase, 32'(obs()), 32'(exp_q.pop_front()));
    valid_i = v;
    cnt_i   = c;
    clear_i = clr;
    sv = 1'b0; inc = 1'b0; er = 1'b0;
    if (clr) begin
      m_state = 0; m_good = 0; m_err_cnt = 0;
    end else if (v) begin
      if (m_state == 0) begin
        m_state = 1; m_good = 0;
      end else begin
        d = c - m_prev;
        if (d == 4'd0 || d == 4'd2) begin
          sv  = 1'b1;
          inc = (d == 4'd2);
          if (m_state == 1) begin
            m_good++;
            if (m_good == LOCK_N) m_state = 2;
          end
        end else begin
          if (m_state == 2) begin
            er = 1'b1;
            if (m_err_cnt < 255) m_err_cnt++;
            m_state = 1;
          end
          m_good = 0;
        end
      end
      m_prev = c;
    end
    exp_q.push_back({sv, inc, er, (m_state == 2), exp_err_cnt()});
  endtask

  task automatic run_seq(input string tag, input int vals[$]);
    phase = tag;
    foreach (vals[i]) cycle(1'b1, 4'(vals[i]), 1'b0);
  endtask

  initial begin
    logic [3:0] p;
    // Reset state.
    repeat (2) @(negedge clock);
    check("reset", 32'(obs()), 32'd0);
    reset_n = 1'b1;

    // Seed 3 then steps 0,+2,+2,0; locks on the 4th step.
    run_seq("lock", '{3, 3, 5, 7, 7});
    cycle(1'b0, 4'd0, 1'b0);

    // Re-acquire at an even value, lock at 14, then wrap 14->0->2.
    cycle(1'b0, 4'd0, 1'b1);
    run_seq("wrap", '{8, 10, 12, 14, 14, 0, 2});
    cycle(1'b0, 4'd0, 1'b0);

    // Lock at 5, illegal +1 to 6, then 8 is legal in ACQ.
    cycle(1'b0, 4'd0, 1'b1);
    run_seq("err", '{1, 3, 5, 5, 5, 6});
    cycle(1'b0, 4'd0, 1'b0);
    run_seq("err", '{8});

    // Illegal deltas in ACQ reset good_cnt but raise no error.
    run_seq("acq_illegal", '{0, 1, 3, 5, 7, 9, 9});

    // Many lock/break rounds with random holds and gaps to saturate err_cnt.
    phase = "sat";
    p = 4'd9;
    for (int r = 0; r < 260; r++) begin
      for (int k = 0; k < 5; k++) begin
        if ($urandom_range(0, 3) == 0) cycle(1'b0, 4'($urandom), 1'b0);
        p = p + 4'(2 * $urandom_range(0, 1));
        cycle(1'b1, p, 1'b0);
      end
      p = p + 4'd1;
      cycle(1'b1, p, 1'b0);
    end
    cycle(1'b0, 4'd0, 1'b0);
    cycle(1'b0, 4'd0, 1'b0);
`ifdef CNT_STEP_DECODER_ERR_CNT_EN
    check("err_cnt_sat", 32'(err_cnt_o), 32'd255);
`else
    check("err_cnt_sat", 32'(err_cnt_o), 32'd0);
`endif

    // Lock, then clear and valid together; next sample only re-seeds.
    p = p + 4'd2;
    run_seq("clear", '{p, p + 2, p + 4, p + 4});
    cycle(1'b1, p + 4'd6, 1'b1);
    run_seq("clear", '{p + 7, p + 9, p + 11, p + 11, p + 13, p + 15});

    // Asynchronous reset while locked.
    phase = "pre_rst";
    @(negedge clock);
    if (exp_q.size() > 0) check(phase, 32'(obs()), 32'(exp_q.pop_front()));
    check("pre_rst_locked", 32'(locked_o), 32'd1);
    valid_i = 1'b0;
    #2 reset_n = 1'b0;
    #1 check("async_rst", 32'(obs()), 32'd0);
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // After reset the first sample only seeds.
    run_seq("post_rst", '{4, 6, 6});
    cycle(1'b0, 4'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cnt_step_decoder.md
# cnt_step_decoder

Observer-side decoder for the 4-bit synchronous step counter, whose step per cycle is +2 when both enables are set and hold otherwise. It samples the counter value stream and recovers the per-cycle step. It checks the stream for legality and tracks lock and error state. It sits on the consumer side of the counter interface, in test harnesses and in downstream logic that must infer enable activity from the count alone.

## Interface
Parameters:
- CNT_W, 4, width of the observed counter value.
- LOCK_N, 4, number of consecutive legal steps needed to go from ACQ to LOCKED (range 1..15).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear_i  in  1  synchronous clear: return to UNSYNC and zero the error counter.
- valid_i  in  1  cnt_i carries a new sample this cycle.
- cnt_i  in  CNT_W  observed counter value.
- step_valid_o  out  1  registered; a legal step was decoded from the previous valid sample.
- inc2_o  out  1  registered; the decoded step was +2 (both enables high). 0 means hold.
- err_o  out  1  registered one-cycle pulse; an illegal step was seen while LOCKED.
- locked_o  out  1  registered; FSM is in LOCKED.
- err_cnt_o  out  ERR_W  saturating count of err_o pulses.

## Operation
- Legality is judged from delta = (cnt_i − prev) mod 2^CNT_W, where prev is the last valid sample.
  - Legal deltas: 0 (hold) and 2 (+2).
  - Every other delta is illegal, including 1.
- The FSM lives in the shared package and has three states.
- UNSYNC (reset state)
  - On valid_i: store prev, go to ACQ, set good_cnt=0.
  - No step outputs are produced.
- ACQ
  - On valid_i with a legal delta: step_valid_o=1, inc2_o=(delta==2), good_cnt++.
  - When good_cnt reaches LOCK_N, go to LOCKED.
  - On valid_i with an illegal delta: good_cnt=0, stay in ACQ, no err_o, err_cnt_o unchanged.
- LOCKED
  - On valid_i with a legal delta: same step outputs as in ACQ.
  - On valid_i with an illegal delta: err_o=1, err_cnt_o += 1 (saturating at all-ones), go to ACQ, good_cnt=0, no step_valid_o.
- prev is updated on every valid_i sample, legal or not.
- valid_i=0: state, prev and good_cnt hold; step_valid_o, inc2_o and err_o are 0 next cycle.
- clear_i has priority over valid_i in the same cycle: the sample is discarded, the FSM goes to UNSYNC, err_cnt_o=0 and prev is invalidated.
- Wrap-around is handled by modulo arithmetic:
  - 14→0 and 15→1 are legal +2 steps.
  - 0→14 is delta 14, which is illegal.

## Timing
- Latency: a sample on cycle N drives step_valid_o, inc2_o, err_o and locked_o on cycle N+1; all outputs are registered.
- locked_o rises on the cycle after the LOCK_N-th legal step is sampled, coincident with that step's step_valid_o.
- locked_o falls on the same cycle err_o pulses.
- Reset values: step_valid_o=0, inc2_o=0, err_o=0, locked_o=0, err_cnt_o=0; FSM=UNSYNC, good_cnt=0.
- Reset asserted mid-stream clears everything immediately (asynchronously). The first sample after release only re-seeds prev.
- Back-to-back valid samples are supported every cycle; there is no backpressure.

## Configuration
- CNT_STEP_DECODER_ERR_CNT_EN
  - Defined: err_cnt_o is a saturating ERR_W-bit counter, as described above.
  - Undefined: the counter register is not built; err_cnt_o is tied to 0. err_o, the FSM and all other behaviour are unchanged.

## Structure
- Package cnt_dec_pkg contains:
  - the state enum (UNSYNC, ACQ, LOCKED);
  - step-class constants (STEP_HOLD=0, STEP_INC2=2);
  - a localparam for the good_cnt width, $clog2(LOCK_N+1).
- Sub-module cnt_step_classify: purely combinational modulo subtract of cnt_i and prev. Outputs legal and is_inc2.
- The top level holds the FSM, prev, good_cnt, output registers and the optional error counter.

## Test plan
- Reset, then valid samples 3,3,5,7,7 with LOCK_N=4: first sample seeds prev only; then step_valid_o=1 with inc2_o=0,1,1,0; locked_o=1 in the cycle of the 4th step.
- Locked at 14, then samples 0,2: both steps legal with inc2_o=1 (wrap-around); no err_o.
- Locked at 5, then sample 6: err_o pulses one cycle, err_cnt_o=1, locked_o=0. Next sample 8 is legal in ACQ.
- Samples in ACQ 0,1,3: delta 1 gives no err_o and no err_cnt change and resets good_cnt; delta 2 then counts as the first good step.
- Force err_cnt_o to 255 (ERR_W=8) and inject an illegal step in LOCKED: err_cnt_o stays 255 and err_o still pulses. With the macro undefined, err_cnt_o is 0 throughout.
- clear_i and valid_i high in the same cycle while LOCKED: next cycle locked_o=0 and err_cnt_o=0; the following sample only re-seeds. Assert reset_n low mid-stream: all outputs go to 0 immediately.
